// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : ID-stage load-use hazard detector. Compares the destination
//               register of a load sitting in ID/EX against both source
//               registers of the instruction in IF/ID. It raises a
//               combinational stall and derives the PC hold, IF/ID hold and
//               ID/EX bubble strobes from it. It also keeps a registered copy
//               of the stall, plus optional performance counters that exist
//               only when the macro HDU_PERF_COUNTERS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic [1:0]            hazard_src,
  output logic                  stall_d,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      load_use_events
);

  localparam logic [REG_ADDR_W-1:0] c_REG_ZERO = '0;

  // Comparator results. They are qualified by the load flag and by a
  // non-zero rd further down, so that x0 can never produce a hazard.
  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_stall;

  // Register-match comparators. They are purely combinational and do not
  // depend on clk or rst, so they stay valid even while the unit is held
  // in reset.
  always_comb begin
    w_rd_nonzero = (idex_rd != c_REG_ZERO);
    w_rs1_hit    = (idex_rd == ifid_rs1);
    w_rs2_hit    = (idex_rd == ifid_rs2);
  end

  // Hazard decision and the derived pipeline-control strobes. The load
  // flag is ANDed in directly with no masking, so an unknown load flag
  // propagates to stall.
  always_comb begin
    w_stall       = idex_memread & w_rd_nonzero & (w_rs1_hit | w_rs2_hit);
    stall         = w_stall;
    pc_write      = ~w_stall;
    ifid_write    = ~w_stall;
    idex_bubble   = w_stall;
    hazard_src    = 2'b00;
    hazard_src[0] = w_stall & w_rs1_hit;
    hazard_src[1] = w_stall & w_rs2_hit;
  end

  // Previous-cycle stall. This flop also provides the edge reference that
  // the event counter uses.
  logic stall_prev_q;

  // Capture stall on every rising edge. Reset clears it asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_prev_q <= 1'b0;
    end else begin
      stall_prev_q <= w_stall;
    end
  end

  assign stall_d = stall_prev_q;

`ifdef HDU_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;
  logic [CNT_W-1:0] load_use_events_q;
  logic [CNT_W-1:0] load_use_events_d;
  logic             w_stall_rise;

  // Next-state logic for the counters. Stall cycles count every stalled
  // edge. Events count only the first edge of a stall run. Both counters
  // wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    load_use_events_d = load_use_events_q;
    w_stall_rise      = w_stall & ~stall_prev_q;
    if (w_stall) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (w_stall_rise) begin
      load_use_events_d = load_use_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter registers. Reset clears them immediately, even in the middle
  // of a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q    <= '0;
      load_use_events_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      load_use_events_q <= load_use_events_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = load_use_events_q;
`else
  // The counters are compiled out, so both outputs are tied to zero.
  assign stall_cycles    = '0;
  assign load_use_events = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Self-checking bench for hazard_detection_unit. It runs
//               directed vectors, randomized traffic checked against a
//               behavioural model, back-to-back stalls and an asynchronous
//               reset applied mid-stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;
`ifdef HDU_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  idex_memread;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  stall;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic [1:0]            hazard_src;
  logic                  stall_d;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      load_use_events;

  int checks   = 0;
  int failures = 0;

  // Reference model state: previous stall, stalled-cycle count, rising edges.
  bit          m_prev;
  int unsigned m_cyc;
  int unsigned m_ev;

  hazard_detection_unit #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .stall           (stall),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .hazard_src      (hazard_src),
    .stall_d         (stall_d),
    .stall_cycles    (stall_cycles),
    .load_use_events (load_use_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load-use rule: a load whose non-zero rd feeds either source register.
  function automatic bit f_hazard(input bit mr, input int rd, input int rs1, input int rs2);
    return mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
  endfunction

  function automatic logic [1:0] f_src(input bit mr, input int rd, input int rs1, input int rs2);
    logic [1:0] s;
    s = 2'b00;
    if (f_hazard(mr, rd, rs1, rs2)) begin
      s[0] = (rd == rs1);
      s[1] = (rd == rs2);
    end
    return s;
  endfunction

  task automatic drive(input bit mr, input int rd, input int rs1, input int rs2);
    idex_memread = mr;
    idex_rd      = rd[REG_ADDR_W-1:0];
    ifid_rs1     = rs1[REG_ADDR_W-1:0];
    ifid_rs2     = rs2[REG_ADDR_W-1:0];
    #1;
  endtask

  // Advance one clock edge and update the model from the inputs present at that edge.
  task automatic step();
    bit h;
    h = f_hazard(idex_memread, int'(idex_rd), int'(ifid_rs1), int'(ifid_rs2));
    @(posedge clk);
    if (!rst) begin
      if (PERF && h) m_cyc = m_cyc + 1;
      if (PERF && h && !m_prev) m_ev = m_ev + 1;
      m_prev = h;
    end
    #1;
  endtask

  task automatic model_reset();
    m_prev = 1'b0;
    m_cyc  = 0;
    m_ev   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b1, 7, 7, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (stall_d !== 1'b0 || stall_cycles !== '0 || load_use_events !== '0) begin
      failures++;
      $display("FAIL reset_state: stall_d=%b cyc=%0d ev=%0d required 0/0/0", stall_d, stall_cycles, load_use_events);
    end
    checks++;
    if (stall !== 1'b1 || hazard_src !== 2'b01) begin
      failures++;
      $display("FAIL comb_during_reset: stall=%b src=%b required 1/01", stall, hazard_src);
    end
    rst = 1'b0;
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic test_directed();
    int vec [6][4] = '{'{0,3,1,2}, '{1,1,1,2}, '{1,2,1,2}, '{1,4,1,2}, '{1,5,5,5}, '{1,0,0,0}};
    bit         es;
    logic [1:0] esrc;
    for (int i = 0; i < 6; i++) begin
      drive(vec[i][0] != 0, vec[i][1], vec[i][2], vec[i][3]);
      es   = f_hazard(vec[i][0] != 0, vec[i][1], vec[i][2], vec[i][3]);
      esrc = f_src(vec[i][0] != 0, vec[i][1], vec[i][2], vec[i][3]);
      checks++;
      if (stall !== es || pc_write !== !es || ifid_write !== !es || idex_bubble !== es || hazard_src !== esrc) begin
        failures++;
        $display("FAIL directed[%0d]: stall=%b pcw=%b ifw=%b bub=%b src=%b required stall=%b src=%b",
                 i, stall, pc_write, ifid_write, idex_bubble, hazard_src, es, esrc);
      end
    end
    step();
  endtask

  task automatic test_random();
    bit         mr, es;
    int         rd, rs1, rs2;
    logic [1:0] esrc;
    for (int i = 0; i < 300; i++) begin
      mr  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      rs1 = int'($urandom_range(0, 3));
      rs2 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      drive(mr, rd, rs1, rs2);
      es   = f_hazard(mr, rd, rs1, rs2);
      esrc = f_src(mr, rd, rs1, rs2);
      checks++;
      if (stall !== es || pc_write !== !es || ifid_write !== !es || idex_bubble !== es || hazard_src !== esrc) begin
        failures++;
        $display("FAIL random_comb[%0d]: mr=%b rd=%0d rs1=%0d rs2=%0d stall=%b src=%b required %b/%b",
                 i, mr, rd, rs1, rs2, stall, hazard_src, es, esrc);
      end
      step();
      checks++;
      if (stall_d !== m_prev || stall_cycles !== CNT_W'(m_cyc) || load_use_events !== CNT_W'(m_ev)) begin
        failures++;
        $display("FAIL random_seq[%0d]: stall_d=%b cyc=%0d ev=%0d required %b/%0d/%0d",
                 i, stall_d, stall_cycles, load_use_events, m_prev, m_cyc, m_ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0, e0;
    drive(1'b0, 0, 0, 0);
    step();
    c0 = m_cyc;
    e0 = m_ev;
    drive(1'b1, 9, 9, 1);
    step(); step(); step();
    drive(1'b0, 9, 9, 1);
    step();
    drive(1'b1, 9, 1, 9);
    step();
    checks++;
    if (stall_cycles !== CNT_W'(c0 + (PERF ? 4 : 0)) || load_use_events !== CNT_W'(e0 + (PERF ? 2 : 0))) begin
      failures++;
      $display("FAIL back_to_back: cyc=%0d ev=%0d required %0d/%0d",
               stall_cycles, load_use_events, c0 + (PERF ? 4 : 0), e0 + (PERF ? 2 : 0));
    end
    checks++;
    if (stall_d !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_stall_d: stall_d=%b required 1", stall_d);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 6, 6, 6);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b0 || stall_cycles !== '0 || load_use_events !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall: stall_d=%b cyc=%0d ev=%0d required 0/0/0", stall_d, stall_cycles, load_use_events);
    end
    checks++;
    if (stall !== 1'b1 || hazard_src !== 2'b11 || idex_bubble !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_stall_comb: stall=%b src=%b bub=%b required 1/11/1", stall, hazard_src, idex_bubble);
    end
    model_reset();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (stall_d !== 1'b1 || stall_cycles !== CNT_W'(m_cyc) || load_use_events !== CNT_W'(m_ev)) begin
      failures++;
      $display("FAIL post_reset_resume: stall_d=%b cyc=%0d ev=%0d required 1/%0d/%0d",
               stall_d, stall_cycles, load_use_events, m_cyc, m_ev);
    end
  endtask

  initial begin
    rst          = 1'b1;
    idex_memread = 1'b0;
    idex_rd      = '0;
    ifid_rs1     = '0;
    ifid_rs2     = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
